blake2_input_collector: RTL

Parametrised successor of the BLAKE2 byte-serial input front end. Accepts a command-tagged stream of multi-byte beats under valid/ready flow control, captures the kk/nn/ll configuration bytes, and assembles message bytes into zero-padded compression blocks. Each block is presented with first/last flags and the running byte offset t. It sits between the host-side input port and the BLAKE2 compression core, and back-pressures the host while a block waits for the core.

---
 rtl/blake2_pkg.sv | 21 ++
 rtl/blake2_cfg_capture.sv | 51 +++++
 rtl/blake2_input_collector.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/blake2_pkg.sv
// Shared definitions for the BLAKE2 input front end: beat command codes,
// collector state encoding and the config byte slots.
package blake2_pkg;

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no message in progress
        ST_FILL = 2'd1,   // message in progress, block partially filled
        ST_HOLD = 2'd2    // completed block presented to the core
    } coll_state_t;

    localparam int CFG_KK  = 0;
    localparam int CFG_NN  = 1;
    localparam int CFG_LL  = 2;
    localparam int CFG_NUM = 3;

endpackage

// File: rtl/blake2_cfg_capture.sv
// Captures the kk/nn/ll configuration bytes from successive CONF beats.
// The slot counter saturates after the third byte and is cleared by any
// accepted non-CONF beat, so the next CONF run starts again at kk.
module blake2_cfg_capture
    import blake2_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       conf_we,
    input  logic       cfg_clr,
    input  logic [7:0] conf_byte,
    output logic [7:0] kk,
    output logic [7:0] nn,
    output logic [7:0] ll
);

    logic [1:0] cnt_reg;
    logic [7:0] cfg_reg [CFG_NUM];

    // Slot counter: advance per CONF beat until saturated, clear on other beats
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_reg <= 2'd0;
        end else if (conf_we) begin
            if (cnt_reg != 2'd3) begin
                cnt_reg <= cnt_reg + 2'd1;
            end
        end else if (cfg_clr) begin
            cnt_reg <= 2'd0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CFG_NUM; gi++) begin : g_cfg
            // Config byte register: loaded when the counter points at this slot
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    cfg_reg[gi] <= 8'd0;
                end else if (conf_we && (cnt_reg == 2'(gi))) begin
                    cfg_reg[gi] <= conf_byte;
                end
            end
        end
    endgenerate

    assign kk = cfg_reg[CFG_KK];
    assign nn = cfg_reg[CFG_NN];
    assign ll = cfg_reg[CFG_LL];

endmodule

// File: rtl/blake2_input_collector.sv
// BLAKE2 input collector: assembles a command-tagged beat stream into
// zero-padded compression blocks with first/last flags and byte offset t.
// Optional protocol error detection is built when BLAKE2_INPUT_ERR_EN is
// defined; otherwise err_o is tied low.
//
// Beats always land on IN_BYTES-aligned offsets (only a LAST beat can be
// short, and it closes the block), so the write position is tracked as a
// slot index and each buffer byte has a fixed input lane.
module blake2_input_collector
    import blake2_pkg::*;
#(
    parameter int BLOCK_BYTES = 64,
    parameter int IN_BYTES    = 1,
    parameter int CNT_W       = 64
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [1:0]                     cmd_i,
    input  logic [8*IN_BYTES-1:0]          data_i,
    input  logic [$clog2(IN_BYTES+1)-1:0]  nbytes_i,
    output logic [7:0]                     kk_o,
    output logic [7:0]                     nn_o,
    output logic [7:0]                     ll_o,
    output logic                           block_v_o,
    input  logic                           block_ready_i,
    output logic [8*BLOCK_BYTES-1:0]       block_o,
    output logic                           block_first_o,
    output logic                           block_last_o,
    output logic [CNT_W-1:0]               block_t_o,
    output logic                           err_o
);

    localparam int NB_W      = $clog2(IN_BYTES + 1);
    localparam int NSLOT     = BLOCK_BYTES / IN_BYTES;
    localparam int SLOT_W    = $clog2(NSLOT + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);
    localparam logic [NB_W-1:0]   FULL_N    = NB_W'(IN_BYTES);

    coll_state_t       state_reg, state_next;
    logic [SLOT_W-1:0] slot_reg;
    logic [CNT_W-1:0]  t_reg;
    logic              first_reg;
    logic              last_reg;
    logic              ready_reg;
    logic [7:0]        buf_reg [BLOCK_BYTES];

    logic              accept;
    logic              handshake;
    logic              do_start;
    logic              do_write;
    logic              do_complete;
    logic              is_last;
    logic [NB_W-1:0]   wr_n;
    logic [NB_W-1:0]   n_last;
    logic [SLOT_W-1:0] wr_slot;

    assign accept    = valid_i & ready_reg;
    assign handshake = (state_reg == ST_HOLD) & block_ready_i;
    // An oversized LAST count is clamped so only real lanes are written
    assign n_last    = (nbytes_i > FULL_N) ? FULL_N : nbytes_i;
    // A message-opening beat always writes at slot 0
    assign wr_slot   = do_start ? '0 : slot_reg;

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (do_complete) begin
                    state_next = ST_HOLD;
                end else if (do_start) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (do_complete) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (block_ready_i) begin
                    state_next = last_reg ? ST_IDLE : ST_FILL;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Beat decode: which accepted beats write, restart or close the block
    always_comb begin
        do_start    = 1'b0;
        do_write    = 1'b0;
        do_complete = 1'b0;
        is_last     = 1'b0;
        wr_n        = FULL_N;
        if (accept) begin
            unique case (cmd_i)
                CMD_START: begin
                    do_start    = 1'b1;
                    do_write    = 1'b1;
                    do_complete = (LAST_SLOT == '0);
                end
                CMD_DATA: begin
                    if (state_reg == ST_FILL) begin
                        do_write    = 1'b1;
                        do_complete = (slot_reg == LAST_SLOT);
                    end
                end
                CMD_LAST: begin
                    do_start    = (state_reg == ST_IDLE);
                    do_write    = 1'b1;
                    do_complete = 1'b1;
                    is_last     = 1'b1;
                    wr_n        = n_last;
                end
                default: ;
            endcase
        end
    end

    // Block control: write slot, running offset, flags and the ready bubble
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot_reg  <= '0;
            t_reg     <= '0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            // Held low through HOLD and for one cycle after the handshake
            ready_reg <= (state_reg != ST_HOLD) && (state_next != ST_HOLD);
            if (handshake) begin
                slot_reg  <= '0;
                first_reg <= 1'b0;
                last_reg  <= 1'b0;
            end else if (do_write) begin
                slot_reg <= wr_slot + SLOT_W'(1);
                if (do_start) begin
                    first_reg <= 1'b1;
                end
                if (do_complete) begin
                    last_reg <= is_last;
                end
            end
            if (do_write) begin
                t_reg <= (do_start ? '0 : t_reg) + CNT_W'(wr_n);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
            localparam int LANE = gi % IN_BYTES;
            localparam int SLOT = gi / IN_BYTES;
            logic hit;
            assign hit = do_write && (wr_slot == SLOT_W'(SLOT)) && (wr_n > NB_W'(LANE));

            // Buffer byte: cleared on handshake or message start, else loaded from its lane
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    buf_reg[gi] <= 8'd0;
                end else if (handshake) begin
                    buf_reg[gi] <= 8'd0;
                end else if (hit) begin
                    buf_reg[gi] <= data_i[8*LANE +: 8];
                end else if (do_start) begin
                    buf_reg[gi] <= 8'd0;
                end
            end

            assign block_o[8*gi +: 8] = buf_reg[gi];
        end
    endgenerate

    blake2_cfg_capture u_cfg (
        .clk       (clk),
        .nreset    (nreset),
        .conf_we   (accept && (cmd_i == CMD_CONF)),
        .cfg_clr   (accept && (cmd_i != CMD_CONF)),
        .conf_byte (data_i[7:0]),
        .kk        (kk_o),
        .nn        (nn_o),
        .ll        (ll_o)
    );

`ifdef BLAKE2_INPUT_ERR_EN
    logic err_reg;
    logic err_hit;

    assign err_hit = ((cmd_i == CMD_DATA)  && (state_reg == ST_IDLE))
                  || ((cmd_i == CMD_START) && (state_reg == ST_FILL) && (slot_reg != '0))
                  || ((cmd_i == CMD_CONF)  && (state_reg != ST_IDLE))
                  || ((cmd_i == CMD_LAST)  && (nbytes_i > FULL_N))
                  || ((cmd_i == CMD_LAST)  && (nbytes_i == '0)
                      && (state_reg == ST_FILL) && (slot_reg == '0));

    // Sticky protocol error flag
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_reg <= 1'b0;
        end else if (accept && err_hit) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

    assign ready_o       = ready_reg;
    assign block_v_o     = (state_reg == ST_HOLD);
    assign block_first_o = first_reg;
    assign block_last_o  = last_reg;
    assign block_t_o     = t_reg;

endmodule
